// File: rtl/riscv_hazard_ctrl.sv
// riscv_hazard_ctrl
// Pipeline hazard controller for the 5-stage RISC-V core. It combines four
// hazard sources into per-stage stall/flush controls:
//   - data-memory back-pressure (freeze everything),
//   - EX-stage redirects (flush IF/ID and ID/EX),
//   - multi-cycle MUL/DIV (hold EX for the op latency),
//   - load-use dependencies (one bubble into ID/EX).
// A two-state FSM with a down-counter tracks the MUL/DIV occupancy, and a
// saturating counter records how many cycles the front end was stalled.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   id_rs1/id_rs2         source registers of the ID instruction
//   id_uses_rs1/rs2       ID instruction really reads rs1 / rs2
//   ex_valid              EX holds a real instruction
//   ex_rd                 EX destination register
//   ex_is_load/mul/div    EX instruction class
//   ex_redirect_valid     EX resolved a taken branch / jump / mispredict
//   mem_stall             data memory not ready
//   stall_if/id/ex        hold PC, IF/ID, ID/EX
//   flush_id, flush_ex    clear IF/ID, bubble into ID/EX
//   md_done               last cycle of a MUL/DIV, EX result valid
//   md_busy               FSM is holding a MUL/DIV
//   perf_stall_cycles     saturating count of cycles with stall_if high
module riscv_hazard_ctrl #(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 34,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rd,
    input  logic        ex_is_load,
    input  logic        ex_is_mul,
    input  logic        ex_is_div,
    input  logic        ex_redirect_valid,
    input  logic        mem_stall,
    output logic        stall_if,
    output logic        stall_id,
    output logic        stall_ex,
    output logic        flush_id,
    output logic        flush_ex,
    output logic        md_done,
    output logic        md_busy,
    output logic [15:0] perf_stall_cycles
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    // The cycle that accepts the op and the final md_done cycle are not
    // counted, hence LAT-2 as the load value.
    localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 2);
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 2);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [15:0]      perf_reg;

    logic is_run;
    logic md_start;
    logic rs1_hit, rs2_hit;
    logic load_use;

    assign is_run   = (state_reg == RUN);
    assign md_start = is_run & ex_valid & (ex_is_mul | ex_is_div) & ~mem_stall;
    assign rs1_hit  = id_uses_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit  = id_uses_rs2 & (id_rs2 == ex_rd);
    assign load_use = is_run & ex_valid & ex_is_load & (ex_rd != 5'd0)
                    & (rs1_hit | rs2_hit);

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next state and control outputs
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        stall_ex   = 1'b0;
        flush_id   = 1'b0;
        flush_ex   = 1'b0;
        md_done    = 1'b0;

        if (state_reg == MD_BUSY) begin
            // The op keeps progressing regardless of memory back-pressure;
            // mem_stall only masks the outputs below.
            if (cnt_reg != '0) begin
                cnt_next = cnt_reg - CNT_W'(1);
                stall_if = 1'b1;
                stall_id = 1'b1;
                stall_ex = 1'b1;
            end else begin
                state_next = RUN;
                md_done    = ~mem_stall;
            end
        end else if (!mem_stall) begin
            if (ex_redirect_valid) begin
                // Redirect wins over a pending load-use or MUL/DIV start.
                flush_id = 1'b1;
                flush_ex = 1'b1;
            end else if (md_start) begin
                stall_if   = 1'b1;
                stall_id   = 1'b1;
                stall_ex   = 1'b1;
                state_next = MD_BUSY;
                cnt_next   = ex_is_div ? DIV_INIT : MUL_INIT;
            end else if (load_use) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                flush_ex = 1'b1;
            end
        end

        if (mem_stall) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            stall_ex = 1'b1;
            flush_id = 1'b0;
            flush_ex = 1'b0;
        end
    end

    assign md_busy = (state_reg == MD_BUSY);

    // Saturating front-end stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_reg <= 16'd0;
        end else if (stall_if && (perf_reg != 16'hFFFF)) begin
            perf_reg <= perf_reg + 16'd1;
        end
    end

    assign perf_stall_cycles = perf_reg;

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Self-checking bench for riscv_hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against an
// occupancy-age model of the MUL/DIV unit.
module tb_riscv_hazard_ctrl;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 34;
    localparam int CNT_W   = 6;

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2;
    logic        ex_valid, ex_is_load, ex_is_mul, ex_is_div;
    logic        ex_redirect_valid, mem_stall;
    logic        stall_if, stall_id, stall_ex, flush_id, flush_ex;
    logic        md_done, md_busy;
    logic [15:0] perf_stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    riscv_hazard_ctrl #(
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_uses_rs1      (id_uses_rs1),
        .id_uses_rs2      (id_uses_rs2),
        .ex_valid         (ex_valid),
        .ex_rd            (ex_rd),
        .ex_is_load       (ex_is_load),
        .ex_is_mul        (ex_is_mul),
        .ex_is_div        (ex_is_div),
        .ex_redirect_valid(ex_redirect_valid),
        .mem_stall        (mem_stall),
        .stall_if         (stall_if),
        .stall_id         (stall_id),
        .stall_ex         (stall_ex),
        .flush_id         (flush_id),
        .flush_ex         (flush_ex),
        .md_done          (md_done),
        .md_busy          (md_busy),
        .perf_stall_cycles(perf_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {stall_if, stall_id, stall_ex, flush_id, flush_ex, md_done, md_busy}
    logic [6:0] dut_vec;
    assign dut_vec = {stall_if, stall_id, stall_ex, flush_id, flush_ex, md_done, md_busy};

    // Reference model: m_age counts cycles since a MUL/DIV was accepted
    // (0 = no op in flight), m_lat is that op's latency.
    int          m_age;
    int          m_lat;
    int          m_perf;
    logic [7:0]  exp_vec;   // dut_vec layout plus bit 0 = op accepted this cycle

    function automatic logic [7:0] model_outs(
        input int age, input int lat,
        input logic ms, input logic rv, input logic ev, input logic ld,
        input logic mu, input logic dv, input logic [4:0] rd,
        input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2);
        logic [7:0] o;
        o = 8'd0;
        if (age > 0) begin
            o[1] = 1'b1;
            if (age == lat - 1) begin
                o[2] = !ms;
                if (ms) o[7:5] = 3'b111;
            end else begin
                o[7:5] = 3'b111;
            end
        end else if (ms) begin
            o[7:5] = 3'b111;
        end else if (rv) begin
            o[4:3] = 2'b11;
        end else if (ev && (mu || dv)) begin
            o[7:5] = 3'b111;
            o[0]   = 1'b1;
        end else if (ev && ld && rd != 5'd0 &&
                     ((u1 && r1 == rd) || (u2 && r2 == rd))) begin
            o[7:6] = 2'b11;
            o[3]   = 1'b1;
        end
        return o;
    endfunction

    always_comb begin
        exp_vec = model_outs(m_age, m_lat, mem_stall, ex_redirect_valid, ex_valid,
                             ex_is_load, ex_is_mul, ex_is_div, ex_rd,
                             id_rs1, id_rs2, id_uses_rs1, id_uses_rs2);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_age  <= 0;
            m_lat  <= 0;
            m_perf <= 0;
        end else begin
            if (exp_vec[7] && m_perf < 65535) m_perf <= m_perf + 1;
            if (m_age > 0) begin
                m_age <= (m_age == m_lat - 1) ? 0 : m_age + 1;
            end else if (exp_vec[0]) begin
                m_age <= 1;
                m_lat <= ex_is_div ? DIV_LAT : MUL_LAT;
            end
        end
    end

    // Per-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        n_checks++;
        if (dut_vec !== exp_vec[7:1]) begin
            n_fail++;
            $display("FAIL model_ctrl t=%0t got=%b want=%b", $time, dut_vec, exp_vec[7:1]);
        end
        n_checks++;
        if (perf_stall_cycles !== 16'(m_perf)) begin
            n_fail++;
            $display("FAIL model_perf t=%0t got=%0d want=%0d", $time, perf_stall_cycles, m_perf);
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, want);
        end else begin
            $display("ok   %s t=%0t value=%h", name, $time, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_valid = 1'b0; ex_rd = 5'd0; ex_is_load = 1'b0; ex_is_mul = 1'b0;
        ex_is_div = 1'b0; ex_redirect_valid = 1'b0; mem_stall = 1'b0;
    endtask

    // load x5 in EX, "add x6,x5,x1" in ID
    task automatic setup_load_use();
        idle();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5;
        id_rs1 = 5'd5; id_rs2 = 5'd1; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    endtask

    task automatic do_reset();
        tick();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (2) tick();
        check("reset_outs", 16'(dut_vec), 16'h0000);
        check("reset_perf", perf_stall_cycles, 16'h0000);
        rst_n = 1'b1;

        // Load-use: one bubble, then clear
        tick(); setup_load_use(); #1;
        check("lu_stall", 16'(dut_vec), 16'b1100100);
        tick(); idle(); #1;
        check("lu_clear", 16'(dut_vec), 16'h0000);
        tick(); setup_load_use(); ex_rd = 5'd0; id_rs1 = 5'd0; #1;
        check("lu_rd0", 16'(dut_vec), 16'h0000);

        // MUL, latency 3
        tick(); idle(); ex_valid = 1'b1; ex_is_mul = 1'b1; #1;
        check("mul_t0", 16'(dut_vec), 16'b1110000);
        tick(); #1;
        check("mul_t1", 16'(dut_vec), 16'b1110001);
        tick(); #1;
        check("mul_t2", 16'(dut_vec), 16'b0000011);
        tick(); idle(); #1;
        check("mul_t3", 16'(dut_vec), 16'h0000);

        // DIV with mem_stall pulse at T+10..T+12
        do_reset();
        for (int k = 0; k <= 33; k++) begin
            tick();
            idle(); ex_valid = 1'b1; ex_is_div = 1'b1;
            mem_stall = (k >= 10 && k <= 12);
            #1;
            if (k == 11) check("div_memstall", 16'(dut_vec), 16'b1110001);
            if (k == 33) check("div_done", 16'(dut_vec), 16'b0000011);
        end
        tick(); idle(); #1;
        check("div_perf", perf_stall_cycles, 16'd33);
        check("div_run", 16'(dut_vec), 16'h0000);

        // Redirect against load-use, then with mem_stall on top
        tick(); setup_load_use(); ex_redirect_valid = 1'b1; #1;
        check("redir_lu", 16'(dut_vec), 16'b0001100);
        mem_stall = 1'b1; #1;
        check("redir_memstall", 16'(dut_vec), 16'b1110000);

        // Asynchronous reset in the middle of a DIV
        for (int k = 0; k < 5; k++) begin
            tick(); idle(); ex_valid = 1'b1; ex_is_div = 1'b1;
        end
        tick(); #2;
        idle(); rst_n = 1'b0; #1;
        check("rst_mid_outs", 16'(dut_vec), 16'h0000);
        check("rst_mid_perf", perf_stall_cycles, 16'h0000);
        tick(); rst_n = 1'b1;
        for (int k = 0; k <= 33; k++) begin
            tick(); idle(); ex_valid = 1'b1; ex_is_div = 1'b1; #1;
            if (k == 32) check("div2_last_stall", 16'(dut_vec), 16'b1110001);
            if (k == 33) check("div2_done", 16'(dut_vec), 16'b0000011);
        end
        tick(); idle();

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            tick();
            id_rs1            = 5'($urandom_range(0, 3));
            id_rs2            = 5'($urandom_range(0, 3));
            id_uses_rs1       = 1'($urandom_range(0, 1));
            id_uses_rs2       = 1'($urandom_range(0, 1));
            ex_rd             = 5'($urandom_range(0, 3));
            ex_valid          = ($urandom_range(0, 3) != 0);
            ex_is_load        = ($urandom_range(0, 2) == 0);
            ex_is_mul         = ($urandom_range(0, 5) == 0);
            ex_is_div         = ($urandom_range(0, 19) == 0);
            ex_redirect_valid = ($urandom_range(0, 9) == 0);
            mem_stall         = ($urandom_range(0, 7) == 0);
        end

        // Performance counter saturation
        do_reset();
        idle(); mem_stall = 1'b1;
        repeat (70000) tick();
        check("perf_sat", perf_stall_cycles, 16'hFFFF);
        check("perf_sat_stall", 16'(dut_vec), 16'b1110000);
        idle();
        tick(); tick();
        check("perf_sat_hold", perf_stall_cycles, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_hazard_ctrl.md
# riscv_hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. It produces the per-stage stall and flush controls (`stall_if`, `stall_id`, `stall_ex`, `flush_id`, `flush_ex`) from four sources: load-use dependencies, EX-stage redirects, data-memory back-pressure, and multi-cycle MUL/DIV operations. It owns a small FSM and down-counter that hold a MUL/DIV instruction in EX for its full latency. It also keeps a saturating stall-cycle performance counter. It sits beside the EX stage and feeds the IF/ID and ID/EX pipeline-register enables and clears.

## Interface
Parameters:
- `MUL_LAT`, 3: cycles a MUL occupies EX; must be ≥2.
- `DIV_LAT`, 34: cycles a DIV/REM occupies EX; must be ≥2.
- `CNT_W`, 6: down-counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT).

Ports:
- `clk` in 1: core clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_rs1`, `id_rs2` in 5: source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2` in 1: ID instruction actually reads rs1 / rs2.
- `ex_valid` in 1: EX holds a real (non-bubble) instruction.
- `ex_rd` in 5: destination register of the EX instruction.
- `ex_is_load` in 1: EX instruction is a load.
- `ex_is_mul` in 1: EX instruction is MUL/MULH*.
- `ex_is_div` in 1: EX instruction is DIV*/REM*.
- `ex_redirect_valid` in 1: EX resolved a taken branch/jump/mispredict.
- `mem_stall` in 1: data memory not ready; freeze the pipe.
- `stall_if`, `stall_id`, `stall_ex` out 1: hold PC / IF-ID / ID-EX.
- `flush_id` out 1: clear IF/ID to bubble.
- `flush_ex` out 1: insert bubble into ID/EX.
- `md_done` out 1: last cycle of a multi-cycle op; EX result is valid.
- `md_busy` out 1: FSM in MD_BUSY.
- `perf_stall_cycles` out 16: count of cycles with `stall_if`=1, saturating.

## Operation
- FSM states: RUN, MD_BUSY. Reset: state=RUN, cnt=0, `perf_stall_cycles`=0.
- All control outputs are combinational from state, cnt and inputs. With `rst_n` low and inputs at 0, every output reads 0.
- `md_start` = RUN & `ex_valid` & (`ex_is_mul` | `ex_is_div`) & !`mem_stall`. DIV takes precedence if both are set.
- `load_use` = RUN & `ex_valid` & `ex_is_load` & `ex_rd`≠0 & ((`id_uses_rs1` & `id_rs1`==`ex_rd`) | (`id_uses_rs2` & `id_rs2`==`ex_rd`)).
- Priority, highest first:
  1. `mem_stall`: `stall_if`=`stall_id`=`stall_ex`=1; no flush.
  2. `ex_redirect_valid` (RUN only): `flush_id`=`flush_ex`=1; no stall; `load_use` suppressed.
  3. `md_start`: all three stalls asserted; next state MD_BUSY; cnt ← LAT−2.
  4. MD_BUSY with cnt≠0: all three stalls asserted; cnt ← cnt−1.
  5. MD_BUSY with cnt==0: `md_done`=1; no stall; next state RUN.
  6. `load_use`: `stall_if`=`stall_id`=1 and `flush_ex`=1 (bubble).
- In MD_BUSY the counter keeps decrementing and the FSM returns to RUN even while `mem_stall` is high. `mem_stall` still forces all stalls. `md_done` is gated off while `mem_stall` is high.
- `md_start` never fires in MD_BUSY, so the same op does not retrigger.
- `md_busy` = (state==MD_BUSY).
- `perf_stall_cycles` increments each cycle `stall_if`=1 and saturates at 0xFFFF.

## Timing
- Op accepted at cycle T occupies EX for cycles T..T+LAT−1.
- Stalls are asserted at T..T+LAT−2, i.e. LAT−1 cycles.
- `md_done` and stall release occur at T+LAT−1. State is RUN at T+LAT.
- Load-use costs exactly one bubble cycle. On the next cycle the load sits in MEM, so the hazard clears.
- Redirect flush is the same cycle as `ex_redirect_valid`, with zero added latency.
- Asserting `rst_n` low mid MD_BUSY returns the FSM to RUN, cnt=0 and stalls=0 immediately and asynchronously.

## Test plan
- Load x5 in EX, ID `add x6,x5,x1` → one cycle of `stall_if`=`stall_id`=`flush_ex`=1, then 0. Repeat with `ex_rd`=0 → no stall.
- MUL in EX at T with MUL_LAT=3 → stalls at T and T+1; `md_done`=1 at T+2; `md_busy` high at T+1 and T+2.
- DIV with DIV_LAT=34 plus `mem_stall` pulsed at T+10..T+12 → `md_done` at T+33; no stall at T+33; `perf_stall_cycles`=33.
- `ex_redirect_valid` coincident with a load-use match → `flush_id`=`flush_ex`=1 and all stalls 0. Same with `mem_stall`=1 → all stalls 1, no flush.
- `rst_n` pulled low at T+5 of a DIV → all outputs 0 immediately; a DIV issued after reset releases completes normally.
- Hold `stall_if` for 70000 cycles via `mem_stall` → `perf_stall_cycles` saturates at 0xFFFF.
